plab2_proc_muldiv_iter: RTL and testbench

PLAB2_PROC_MULDIV_ITER -- requirements
Module: plab2_proc_muldiv_iter

---
 rtl/plab2_proc_muldiv_iter.sv | 148 ++++++++++++++
 tb/tb_plab2_proc_muldiv_iter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/plab2_proc_muldiv_iter.sv
// Iterative 32-bit MUL/DIV/DIVU/REM/REMU unit: one shift-add or restoring step per cycle.
// Define PLAB2_PROC_MULDIV_EARLY_EXIT_EN to let MUL finish once the multiplier drains to zero.
module plab2_proc_muldiv_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [2:0]  req_fn,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_data
);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  logic [2:0]  fn_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [31:0] acc;
  logic [5:0]  cnt;
  logic        neg_q;
  logic        neg_r;

  logic        is_sdiv;
  logic [31:0] a_ld;
  logic [31:0] b_ld;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] a_n;
  logic [31:0] b_n;
  logic [31:0] acc_n;
  logic [31:0] result;
  logic        early;
  logic        last;

  // Signed ops work on magnitudes; sign is restored at the end
  assign is_sdiv = (req_fn == FN_DIV) || (req_fn == FN_REM);
  assign a_ld    = (is_sdiv && req_a[31]) ? -req_a : req_a;
  assign b_ld    = (is_sdiv && req_b[31]) ? -req_b : req_b;

  // a_r: multiplicand (MUL) or dividend/quotient shifter (div)
  // acc: product (MUL) or partial remainder (div)
  always_comb begin
    a_n    = a_r;
    b_n    = b_r;
    acc_n  = acc;
    rem_sh = {acc, a_r[31]};
    diff   = rem_sh - {1'b0, b_r};
    if (fn_r == FN_MUL) begin
      acc_n = b_r[0] ? acc + a_r : acc;
      a_n   = a_r << 1;
      b_n   = b_r >> 1;
    end else if (!diff[32]) begin
      acc_n = diff[31:0];
      a_n   = {a_r[30:0], 1'b1};
    end else begin
      acc_n = rem_sh[31:0];
      a_n   = {a_r[30:0], 1'b0};
    end
  end

  always_comb begin
    result = '0;
    case (fn_r)
      FN_MUL:  result = acc_n;
      FN_DIV:  result = neg_q ? -a_n : a_n;
      FN_DIVU: result = a_n;
      FN_REM:  result = neg_r ? -acc_n : acc_n;
      FN_REMU: result = acc_n;
      default: result = '0;
    endcase
  end

`ifdef PLAB2_PROC_MULDIV_EARLY_EXIT_EN
  assign early = (fn_r == FN_MUL) && (b_n == '0);
`else
  assign early = 1'b0;
`endif

  assign last = (cnt == 6'd31) || early;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_rdy   <= 1'b1;
      resp_val  <= 1'b0;
      resp_data <= '0;
      cnt       <= '0;
      fn_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      acc       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_val && req_rdy) begin
            state   <= CALC;
            req_rdy <= 1'b0;
            fn_r    <= req_fn;
            a_r     <= a_ld;
            b_r     <= b_ld;
            acc     <= '0;
            cnt     <= '0;
            // Divide-by-zero keeps the all-ones quotient unsigned
            neg_q   <= is_sdiv && (req_a[31] ^ req_b[31])
                       && (req_b != '0);
            neg_r   <= is_sdiv && req_a[31];
          end
        end
        CALC: begin
          a_r <= a_n;
          b_r <= b_n;
          acc <= acc_n;
          cnt <= cnt + 6'd1;
          if (last) begin
            state     <= DONE;
            resp_val  <= 1'b1;
            resp_data <= result;
          end
        end
        DONE: begin
          if (resp_rdy) begin
            state    <= IDLE;
            resp_val <= 1'b0;
            req_rdy  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plab2_proc_muldiv_iter.sv
// Directed bench for plab2_proc_muldiv_iter: results, latency, back-pressure, reset.
// Honours PLAB2_PROC_MULDIV_EARLY_EXIT_EN for the expected MUL latencies.
module tb_plab2_proc_muldiv_iter;

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

`ifdef PLAB2_PROC_MULDIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [2:0]  req_fn = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [31:0] resp_data;

  int n_chk  = 0;
  int n_pass = 0;

  plab2_proc_muldiv_iter dut (
    .clk       (clk),
    .reset     (reset),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_fn    (req_fn),
    .req_a     (req_a),
    .req_b     (req_b),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_data (resp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Latency counts the accepting edge as 1
  task automatic do_op(input string tag, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int n;
    @(negedge clk);
    check({tag, ".rdy"}, 32'(req_rdy), 32'd1);
    req_val  = 1'b1;
    req_fn   = fn;
    req_a    = a;
    req_b    = b;
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    req_val = 1'b0;
    req_a   = 32'hDEAD_BEEF;
    req_b   = 32'h0BAD_F00D;
    n = 1;
    while (!resp_val && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check({tag, ".dat"}, resp_data, exp);
    @(posedge clk);
    #1;
    check({tag, ".idle"}, 32'(req_rdy), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    #1 reset = 1'b1;
    #2;
    check("rst.rdy", 32'(req_rdy), 32'd1);
    check("rst.val", 32'(resp_val), 32'd0);
    check("rst.dat", resp_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    do_op("mul7x6", FN_MUL, 32'd7, 32'd6, 32'd42, EE ? 4 : 33);
    do_op("div-7/2", FN_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem-7/2", FN_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu", FN_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    do_op("remu", FN_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 33);
    do_op("div7/-2", FN_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    do_op("rem7/-2", FN_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    do_op("divu/0", FN_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
    do_op("remu/0", FN_REMU, 32'd5, 32'd0, 32'd5, 33);
    do_op("div-7/0", FN_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 33);
    do_op("rem-7/0", FN_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 33);
    do_op("div.ovf", FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    do_op("rem.ovf", FN_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    do_op("mul.m1", FN_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
    do_op("mul.msb", FN_MUL, 32'd1, 32'h8000_0000, 32'h8000_0000, 33);
    do_op("mul.sh", FN_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, EE ? 6 : 33);
    do_op("mul9x1", FN_MUL, 32'd9, 32'd1, 32'd9, EE ? 2 : 33);
    do_op("mul.b0", FN_MUL, 32'd9, 32'd0, 32'd0, EE ? 2 : 33);
    do_op("rsv5", 3'd5, 32'd3, 32'd4, 32'd0, 33);
    do_op("rsv7", 3'd7, 32'd3, 32'd4, 32'd0, 33);

    // Back-pressure: result held, new requests ignored
    @(negedge clk);
    req_val  = 1'b1;
    req_fn   = FN_MUL;
    req_a    = 32'd3;
    req_b    = 32'd4;
    resp_rdy = 1'b0;
    @(posedge clk);
    #1;
    req_val = 1'b0;
    n = 1;
    while (!resp_val && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hold.lat", 32'(n), EE ? 32'd4 : 32'd33);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_val = 1'b1;
      req_fn  = FN_DIVU;
      req_a   = 32'd100;
      req_b   = 32'd1;
      @(posedge clk);
      #1;
      check("hold.val", 32'(resp_val), 32'd1);
      check("hold.dat", resp_data, 32'd12);
      check("hold.rdy", 32'(req_rdy), 32'd0);
    end
    @(negedge clk);
    resp_rdy = 1'b1;
    @(posedge clk);
    #1;
    check("rel.rdy", 32'(req_rdy), 32'd1);
    check("rel.val", 32'(resp_val), 32'd0);
    req_val = 1'b0;
    do_op("mul5x5", FN_MUL, 32'd5, 32'd5, 32'd25, EE ? 4 : 33);

    // Reset in the middle of a divide
    @(negedge clk);
    req_val = 1'b1;
    req_fn  = FN_DIV;
    req_a   = 32'd100;
    req_b   = 32'd7;
    @(posedge clk);
    #1;
    req_val = 1'b0;
    repeat (9) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mrst.rdy", 32'(req_rdy), 32'd1);
    check("mrst.val", 32'(resp_val), 32'd0);
    check("mrst.dat", resp_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    do_op("mul2x3", FN_MUL, 32'd2, 32'd3, 32'd6, EE ? 3 : 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
